// File: rtl/kvt_scfifo_param.sv
// Single-clock parameterised FIFO with occupancy counter, almost-full/empty flags,
// overflow/underflow pulses and a selectable registered-read or show-ahead output.
module kvt_scfifo_param #(
  parameter int DW        = 8,
  parameter int DEPTH     = 16,
  parameter int AF_LEVEL  = DEPTH - 2,
  parameter int AE_LEVEL  = 2,
  parameter int SHOWAHEAD = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DW-1:0]              wr_data_i,
  input  logic                       wr_en_i,
  input  logic                       rd_en_i,
  output logic [DW-1:0]              rd_data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       almost_empty_o,
  output logic                       almost_full_o,
  output logic [$clog2(DEPTH):0]     usedw_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int UW = AW + 1;

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [UW-1:0] usedw_q, usedw_d;
  logic [DW-1:0] rdData_q, rdData_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          isEmpty;
  logic          isFull;
  logic          wrAccept;
  logic          rdAccept;
  logic [DW-1:0] headData;

  // Flags come only from the registered count, so enables never reach an output.
  assign isEmpty  = (usedw_q == '0);
  assign isFull   = (usedw_q == UW'(DEPTH));
  assign wrAccept = wr_en_i && !isFull;
  assign rdAccept = rd_en_i && !isEmpty;
  assign headData = mem[rdPtr_q];

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    usedw_d     = usedw_q;
    rdData_d    = rdData_q;
    overflow_d  = wr_en_i && isFull;
    underflow_d = rd_en_i && isEmpty;

    if (wrAccept) wrPtr_d = wrPtr_q + AW'(1);
    if (rdAccept) rdPtr_d = rdPtr_q + AW'(1);

    case ({wrAccept, rdAccept})
      2'b10:   usedw_d = usedw_q + UW'(1);
      2'b01:   usedw_d = usedw_q - UW'(1);
      default: usedw_d = usedw_q;
    endcase

    // In show-ahead mode the register tracks the visible head so it holds while empty.
    if (SHOWAHEAD != 0) begin
      if (!isEmpty) rdData_d = headData;
    end else begin
      if (rdAccept) rdData_d = headData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      usedw_q     <= '0;
      rdData_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      usedw_q     <= usedw_d;
      rdData_q    <= rdData_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never cleared; reset only blocks the write in its cycle.
  always_ff @(posedge clk) begin
    if (!rst && wrAccept) mem[wrPtr_q] <= wr_data_i;
  end

  assign rd_data_o      = ((SHOWAHEAD != 0) && !isEmpty) ? headData : rdData_q;
  assign empty_o        = isEmpty;
  assign full_o         = isFull;
  assign almost_empty_o = (usedw_q <= UW'(AE_LEVEL));
  assign almost_full_o  = (usedw_q >= UW'(AF_LEVEL));
  assign usedw_o        = usedw_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule
